// File: rtl/bp_pkg.sv
// Shared definitions for the gshare branch predictor: counter encodings,
// FSM states, PHT write-op struct and the 2-bit saturating update.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} bp_state_e;

  typedef struct packed {
    logic en;
    logic init;   // 1: sweep write of WNT, 0: training update
    logic taken;
  } pht_wr_t;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST)  ? ST  : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: 2^IDX_W x 2-bit counters, one synchronous read port
// and one write port. No reset; the controller sweeps it during INIT.
module bp_pht
  import bp_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  pht_wr_t          wr,
  input  logic [IDX_W-1:0] wr_idx
);

  logic [1:0] mem [2**IDX_W];

  // Read sees the pre-write value when read and write hit the same entry.
  always_ff @(posedge clk) begin
    rd_ctr <= mem[rd_idx];
    if (wr.en) mem[wr_idx] <= wr.init ? WNT : sat_update(mem[wr_idx], wr.taken);
  end

endmodule

// File: rtl/branch_predictor_ctrl.sv
// Gshare direction predictor with speculative GHR and mispredict recovery.
// Optional resolve/mispredict statistics counters enabled by BP_STATS_EN.
module branch_predictor_ctrl
  import bp_pkg::*;
#(
  parameter int PHT_IDX_W = 10,
  parameter int GHR_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic                 lookup_valid,
  input  logic [31:0]          lookup_pc,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic [PHT_IDX_W-1:0] pred_idx,
  output logic [GHR_W-1:0]     pred_ghr,
  input  logic                 resolve_valid,
  input  logic [PHT_IDX_W-1:0] resolve_idx,
  input  logic [GHR_W-1:0]     resolve_ghr,
  input  logic                 resolve_pred,
  input  logic                 resolve_taken,
  output logic                 flush_req,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts
);

  bp_state_e            state;
  logic [PHT_IDX_W-1:0] init_ptr;
  logic [PHT_IDX_W-1:0] lk_idx;
  logic [PHT_IDX_W-1:0] wr_idx;
  logic [GHR_W-1:0]     ghr;
  logic [1:0]           rd_ctr;
  logic                 mispredict;
  pht_wr_t              wr;

  assign lk_idx     = lookup_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
  assign mispredict = ready & resolve_valid & (resolve_pred != resolve_taken);
  assign flush_req  = mispredict;
  // Counter read is unreset; gate so pred_taken is 0 whenever no prediction is live.
  assign pred_taken = pred_valid & rd_ctr[1];

  logic unused_ok;
  assign unused_ok = ^{lookup_pc[31:PHT_IDX_W+2], lookup_pc[1:0], resolve_ghr[GHR_W-1]};

  always_comb begin
    wr     = '0;
    wr_idx = resolve_idx;
    if (state == INIT) begin
      wr.en  = 1'b1;
      wr.init = 1'b1;
      wr_idx = init_ptr;
    end else if (resolve_valid) begin
      wr.en    = 1'b1;
      wr.taken = resolve_taken;
    end
  end

  bp_pht #(.IDX_W(PHT_IDX_W)) u_pht (
    .clk    (clk),
    .rd_idx (lk_idx),
    .rd_ctr (rd_ctr),
    .wr     (wr),
    .wr_idx (wr_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      init_ptr   <= '0;
      ready      <= 1'b0;
      ghr        <= '0;
      pred_valid <= 1'b0;
      pred_idx   <= '0;
      pred_ghr   <= '0;
    end else begin
      case (state)
        INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == '1) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          pred_valid <= lookup_valid;
          if (lookup_valid) begin
            pred_idx <= lk_idx;
            pred_ghr <= ghr;
          end
          // Recovery wins over the speculative shift of the live prediction.
          if (mispredict)      ghr <= {resolve_ghr[GHR_W-2:0], resolve_taken};
          else if (pred_valid) ghr <= {ghr[GHR_W-2:0], pred_taken};
        end
      endcase
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] br_cnt, mp_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (ready && resolve_valid) br_cnt <= br_cnt + 32'd1;
      if (mispredict)             mp_cnt <= mp_cnt + 32'd1;
    end
  end
  assign stat_branches    = br_cnt;
  assign stat_mispredicts = mp_cnt;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Directed bench for branch_predictor_ctrl: table-level reference model checked
// every cycle, plus literal expectations from hand-worked scenarios.
module tb_branch_predictor_ctrl;
  localparam int IW = 10;
  localparam int GW = 8;
  localparam int N  = 1 << IW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ready;
  logic          lookup_valid = 1'b0;
  logic [31:0]   lookup_pc = '0;
  logic          pred_valid, pred_taken;
  logic [IW-1:0] pred_idx;
  logic [GW-1:0] pred_ghr;
  logic          resolve_valid = 1'b0;
  logic [IW-1:0] resolve_idx = '0;
  logic [GW-1:0] resolve_ghr = '0;
  logic          resolve_pred = 1'b0;
  logic          resolve_taken = 1'b0;
  logic          flush_req;
  logic [31:0]   stat_branches, stat_mispredicts;

  always #5 clk = ~clk;

  branch_predictor_ctrl #(.PHT_IDX_W(IW), .GHR_W(GW)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_idx(pred_idx), .pred_ghr(pred_ghr),
    .resolve_valid(resolve_valid), .resolve_idx(resolve_idx), .resolve_ghr(resolve_ghr),
    .resolve_pred(resolve_pred), .resolve_taken(resolve_taken),
    .flush_req(flush_req), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: whole-table view, init modelled as a cycle count.
  int          m_pht [N];
  int          m_cnt, m_pidx, m_pghr, m_ghr;
  bit          m_ready, m_pv, m_pt, started;
  int unsigned m_br, m_mp;

  always @(posedge clk) begin
    bit mis;
    int opv, opt, oghr, ri;
    started = 1'b1;
    if (rst) begin
      m_cnt = 0; m_ready = 0; m_pv = 0; m_pt = 0;
      m_pidx = 0; m_pghr = 0; m_ghr = 0; m_br = 0; m_mp = 0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == N) begin
        m_ready = 1;
        foreach (m_pht[i]) m_pht[i] = 1;
      end
    end else begin
      opv = m_pv; opt = m_pt; oghr = m_ghr;
      mis = resolve_valid && (resolve_pred != resolve_taken);
      m_pv = lookup_valid;
      if (lookup_valid) begin
        m_pidx = int'((lookup_pc >> 2) & 32'h3FF) ^ oghr;
        m_pt   = (m_pht[m_pidx] >= 2);
        m_pghr = oghr;
      end
      if (resolve_valid) begin
        ri = int'(resolve_idx);
        if (resolve_taken) m_pht[ri] = (m_pht[ri] == 3) ? 3 : m_pht[ri] + 1;
        else               m_pht[ri] = (m_pht[ri] == 0) ? 0 : m_pht[ri] - 1;
        m_br++;
      end
      if (mis) begin
        m_mp++;
        m_ghr = (int'(resolve_ghr) * 2 + int'(resolve_taken)) % 256;
      end else if (opv) begin
        m_ghr = (oghr * 2 + opt) % 256;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ready", {31'd0, ready}, {31'd0, m_ready});
      chk("pred_valid", {31'd0, pred_valid}, {31'd0, m_pv});
      chk("flush_req", {31'd0, flush_req},
          {31'd0, m_ready && resolve_valid && (resolve_pred != resolve_taken)});
      if (m_pv) begin
        chk("pred_taken", {31'd0, pred_taken}, {31'd0, m_pt});
        chk("pred_idx", 32'(pred_idx), m_pidx);
        chk("pred_ghr", 32'(pred_ghr), m_pghr);
      end
`ifdef BP_STATS_EN
      chk("stat_branches", stat_branches, m_br);
      chk("stat_mispredicts", stat_mispredicts, m_mp);
`else
      chk("stat_branches", stat_branches, 32'd0);
      chk("stat_mispredicts", stat_mispredicts, 32'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic res(input int idx, input int g, input bit p, input bit t);
    resolve_valid = 1'b1;
    resolve_idx   = IW'(idx);
    resolve_ghr   = GW'(g);
    resolve_pred  = p;
    resolve_taken = t;
  endtask

  task automatic idle();
    resolve_valid = 1'b0;
    lookup_valid  = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    tick();
    lookup_valid = 1'b0;
  endtask

  initial begin
    tick();
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
    chk("rst_pred_idx", 32'(pred_idx), 32'd0);
    rst = 1'b0;
    repeat (N - 1) tick();
    chk("init_ready_early", {31'd0, ready}, 32'd0);
    tick();
    chk("init_ready_rise", {31'd0, ready}, 32'd1);

    // Fresh table, ghr=0: PC 0x00400010 maps to index 0x004, weakly not-taken.
    lookup(32'h0040_0010);
    chk("lk_valid", {31'd0, pred_valid}, 32'd1);
    chk("lk_idx", 32'(pred_idx), 32'h004);
    chk("lk_taken", {31'd0, pred_taken}, 32'd0);
    chk("lk_ghr", 32'(pred_ghr), 32'h00);
    tick();

    // Two taken resolves mispredicted as not-taken: 01 -> 10 -> 11.
    res(4, 0, 0, 1); #1 chk("flush_1", {31'd0, flush_req}, 32'd1); tick();
    res(4, 0, 0, 1); #1 chk("flush_2", {31'd0, flush_req}, 32'd1); tick();
    res(10'h3FF, 0, 1, 0); #1 chk("flush_3", {31'd0, flush_req}, 32'd1); tick();
    idle();
    lookup(32'h0040_0010);
    chk("trained_idx", 32'(pred_idx), 32'h004);
    chk("trained_taken", {31'd0, pred_taken}, 32'd1);

    // Mispredict in the same cycle as a live prediction: recovery wins.
    res(10'h010, 8'hA5, 0, 1); #1 chk("flush_a5", {31'd0, flush_req}, 32'd1); tick();
    idle();
    lookup(32'h0040_0000);
    chk("recover_ghr", 32'(pred_ghr), 32'h4B);
    chk("recover_idx", 32'(pred_idx), 32'h04B);

    // Eight not-taken from ST saturate at 00; two taken then reach 10.
    for (int i = 0; i < 8; i++) begin
      res(4, 0, 0, 0); #1 chk("no_flush_nt", {31'd0, flush_req}, 32'd0); tick();
    end
    res(4, 0, 1, 1); tick();
    res(4, 0, 1, 1); tick();
    res(10'h3FF, 0, 1, 0); tick();
    idle();
    lookup(32'h0040_0010);
    chk("sat_idx", 32'(pred_idx), 32'h004);
    chk("sat_taken", {31'd0, pred_taken}, 32'd1);

    // Reset mid-RUN with a lookup in flight, then again mid-INIT.
    rst = 1'b1; lookup_valid = 1'b1; tick();
    rst = 1'b0; lookup_valid = 1'b0;
    chk("rerst_ready", {31'd0, ready}, 32'd0);
    chk("rerst_pred_valid", {31'd0, pred_valid}, 32'd0);
    repeat (500) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (N - 1) tick();
    chk("reinit_ready_early", {31'd0, ready}, 32'd0);
    tick();
    chk("reinit_ready_rise", {31'd0, ready}, 32'd1);
    lookup(32'h0040_0010);
    chk("reinit_taken", {31'd0, pred_taken}, 32'd0);
    tick();

    // Ten resolves, three of them mispredicted.
    for (int i = 0; i < 10; i++) begin
      res(i + 32, 0, 0, i < 3);
      tick();
    end
    idle();
    tick();
`ifdef BP_STATS_EN
    chk("stat_br_10", stat_branches, 32'd10);
    chk("stat_mp_3", stat_mispredicts, 32'd3);
`else
    chk("stat_br_off", stat_branches, 32'd0);
    chk("stat_mp_off", stat_mispredicts, 32'd0);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_predictor_ctrl.md
# branch_predictor_ctrl

Gshare direction predictor and misprediction controller for the MIPS pipeline. It holds a 2-bit saturating-counter pattern history table (PHT) and a speculative global history register (GHR), and it answers fetch-side lookups one cycle later. When the decode-stage branch comparator resolves a branch, it trains the PHT and, on a misprediction, restores the GHR and requests a pipeline flush. BLTZAL/BGEZAL resolve through the same path as every other branch, so the GHR is always updated for them.

## Interface
Parameters:
- PHT_IDX_W, 10, PHT index width; PHT holds 2^PHT_IDX_W entries.
- GHR_W, 8, GHR width; must be ≤ PHT_IDX_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- ready  out  1  PHT initialised; lookups and resolves are accepted only while high.
- lookup_valid  in  1  a branch is being fetched.
- lookup_pc  in  32  PC of that branch.
- pred_valid  out  1  registered; prediction for the previous cycle's lookup.
- pred_taken  out  1  predicted direction (counter MSB).
- pred_idx  out  PHT_IDX_W  PHT index used; travels down the pipeline with the branch.
- pred_ghr  out  GHR_W  GHR checkpoint used for the index.
- resolve_valid  in  1  branch resolved this cycle.
- resolve_idx  in  PHT_IDX_W  returned pred_idx.
- resolve_ghr  in  GHR_W  returned pred_ghr.
- resolve_pred  in  1  returned pred_taken.
- resolve_taken  in  1  actual outcome from the branch comparator.
- flush_req  out  1  combinational; misprediction this cycle.
- stat_branches  out  32  resolved-branch count (see Configuration).
- stat_mispredicts  out  32  misprediction count.

## Operation
- FSM states: INIT, RUN.
- Reset enters INIT with init_ptr=0, ghr=0, ready=0, and pred_* = 0.
- INIT:
  - Each cycle writes weakly-not-taken (01) to PHT[init_ptr], then increments init_ptr.
  - After the write to entry 2^PHT_IDX_W−1, the FSM goes to RUN, and ready=1 from the next cycle.
  - lookup_valid and resolve_valid are ignored; flush_req=0.
- RUN lookup:
  - Index = lookup_pc[PHT_IDX_W+1:2] XOR zero-extended ghr.
  - PHT read is synchronous. In the next cycle: pred_valid=1, pred_taken = counter[1], pred_idx = index, and pred_ghr = the ghr value sampled at lookup.
- Speculative shift: on a cycle with pred_valid=1, ghr ← {ghr[GHR_W−2:0], pred_taken} at the clock edge.
- RUN resolve:
  - Counter at resolve_idx is incremented on taken and decremented on not-taken, saturating at 00 and 11.
  - Mispredict = resolve_valid & (resolve_pred != resolve_taken). It drives flush_req in the same cycle.
  - On mispredict, ghr ← {resolve_ghr[GHR_W−2:0], resolve_taken}.
- Simultaneous events:
  - Mispredict recovery overrides the speculative shift in the same cycle.
  - A lookup and a resolve to the same index in the same cycle: the read returns the pre-update value.
  - PHT write-port priority: INIT writes, then resolve training.
- Reset asserted mid-INIT or mid-RUN restarts INIT from entry 0. In-flight predictions are discarded.

## Timing
- Lookup to prediction latency: 1 cycle. Back-to-back lookups: one per cycle.
- Resolve to PHT update: takes effect at the clock edge; visible to lookups issued in the following cycle.
- flush_req has zero latency from the resolve inputs.
- INIT duration: 2^PHT_IDX_W cycles after rst deasserts.

## Configuration
- BP_STATS_EN defined:
  - stat_branches increments on every RUN resolve_valid.
  - stat_mispredicts increments on every mispredict.
  - Both clear on rst and wrap at 2^32.
- BP_STATS_EN undefined: both ports are driven constant 0 and no counters exist. The port list is unchanged.

## Structure
- Shared package bp_pkg holds:
  - Counter encodings SNT=00, WNT=01, WT=10, ST=11.
  - FSM state constants INIT and RUN.
  - The saturating-update function.
- Sub-module bp_pht: 2^PHT_IDX_W × 2-bit array with one synchronous read port and one write port. It contains no reset logic; initialisation is done by the INIT sweep.

## Test plan
- Reset, then 2^PHT_IDX_W idle cycles → ready rises exactly on the following cycle; every entry reads 01.
- Lookup PC 0x00400010 with ghr=0 → next cycle pred_taken=0 and pred_idx=0x004; ghr becomes 0x00.
- Resolve idx 0x004 as taken twice with resolve_pred=0 → flush_req=1 on each resolve; the following lookup of the same PC with ghr restored to match predicts taken.
- Mispredict resolve with resolve_ghr=0xA5 and taken=1, in the same cycle as pred_valid → ghr=0x4B; the speculative shift is dropped.
- Resolve idx 0x004 not-taken eight times from ST → counter saturates at 00; no underflow.
- BP_STATS_EN build: 10 resolves including 3 mispredicts → stat_branches=10 and stat_mispredicts=3. Undefined build: both ports stay 0.
